pool2x2_stream: RTL

Parametrised 2x2, stride-2 pooling stage for the CNN streaming datapath. It sits between the activation layer and the next convolution or the video output. It consumes one raster-ordered feature map per frame and emits the pooled map in raster order. It generalises the fixed 24x24, 32-bit, unsigned max-pool by adding configurable width, image size, signedness and a max/average mode. The line buffer is internal, so no vendor FIFO is needed, and it adds explicit end-of-row and end-of-frame markers.

---
 rtl/pool2x2_stream.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pool2x2_stream.sv
// pool2x2_stream: 2x2, stride-2 max/average pooling over a raster-ordered
// feature map. Even rows pre-combine pixel pairs into an internal line
// buffer, odd rows finish the 2x2 window and emit one registered result.
module pool2x2_stream #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int SIGNED = 0,
    parameter int MODE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic [DATA_W-1:0] out_data,
    output logic              out_vld,
    output logic              out_eol,
    output logic              out_eof
);

    localparam int HALF_W = IMG_W / 2;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int LW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int EW     = DATA_W + 2;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]     colCnt_q, colCnt_d, colPos;
    logic [RW-1:0]     rowCnt_q, rowCnt_d, rowPos;
    logic [DATA_W-1:0] holdReg_q;
    logic [DATA_W:0]   lineBuf_q [HALF_W];
    logic [LW-1:0]     lbIdx;

    logic [EW-1:0]     pairVal, quadVal, quadShift;
    logic [DATA_W-1:0] pooled;

    logic [DATA_W-1:0] outData_q;
    logic              outVld_q, outEol_q, outEof_q;
    logic              unusedBits;

    // Widen a pixel to the two-guard-bit working width, honouring signedness.
    function automatic logic [EW-1:0] extPix(input logic [DATA_W-1:0] x);
        if (SIGNED != 0) return {{2{x[DATA_W-1]}}, x};
        else             return {2'b00, x};
    endfunction

    // Widen a stored pair result (one guard bit) to the working width.
    function automatic logic [EW-1:0] extPair(input logic [DATA_W:0] x);
        if (SIGNED != 0) return {x[DATA_W], x};
        else             return {1'b0, x};
    endfunction

    // Combine two widened operands. Zero-extended unsigned values are never
    // negative at this width, so a signed compare is correct in both modes.
    function automatic logic [EW-1:0] combine(input logic [EW-1:0] a, input logic [EW-1:0] b);
        if (MODE != 0)                 return a + b;
        else if ($signed(a) > $signed(b)) return a;
        else                           return b;
    endfunction

    // Effective raster position of this beat; a frame restart forces (0,0)
    // and the row/column counters advance on every accepted beat.
    always_comb begin
        colPos   = frame_start ? '0 : colCnt_q;
        rowPos   = frame_start ? '0 : rowCnt_q;
        colCnt_d = colPos;
        rowCnt_d = rowPos;
        if (in_vld) begin
            if (colPos == COL_LAST) begin
                colCnt_d = '0;
                rowCnt_d = (rowPos == ROW_LAST) ? '0 : rowPos + 1'b1;
            end else begin
                colCnt_d = colPos + 1'b1;
            end
        end
        lbIdx = LW'(colPos >> 1);
    end

    // Pair and 2x2 combine; average mode divides the four-pixel sum with a
    // floor shift before truncating back to the pixel width.
    always_comb begin
        pairVal = combine(extPix(holdReg_q), extPix(in_data));
        quadVal = combine(extPair(lineBuf_q[lbIdx]), pairVal);
        if (MODE != 0) begin
            if (SIGNED != 0) quadShift = $signed(quadVal) >>> 2;
            else             quadShift = quadVal >> 2;
        end else begin
            quadShift = quadVal;
        end
        pooled = quadShift[DATA_W-1:0];
    end

    assign unusedBits = ^{pairVal[EW-1], quadShift[EW-1:DATA_W]};

    // Line buffer holds even-row pair results; every entry is rewritten
    // before it is read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_vld && !rowPos[0] && colPos[0]) begin
            lineBuf_q[lbIdx] <= pairVal[DATA_W:0];
        end
    end

    // Counters, pixel hold register and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colCnt_q  <= '0;
            rowCnt_q  <= '0;
            holdReg_q <= '0;
            outData_q <= '0;
            outVld_q  <= 1'b0;
            outEol_q  <= 1'b0;
            outEof_q  <= 1'b0;
        end else begin
            colCnt_q <= colCnt_d;
            rowCnt_q <= rowCnt_d;
            outVld_q <= 1'b0;
            outEol_q <= 1'b0;
            outEof_q <= 1'b0;
            if (in_vld && !colPos[0]) begin
                holdReg_q <= in_data;
            end
            if (in_vld && rowPos[0] && colPos[0]) begin
                outVld_q  <= 1'b1;
                outData_q <= pooled;
                outEol_q  <= (colPos == COL_LAST);
                outEof_q  <= (colPos == COL_LAST) && (rowPos == ROW_LAST);
            end
        end
    end

    assign out_data = outData_q;
    assign out_vld  = outVld_q;
    assign out_eol  = outEol_q;
    assign out_eof  = outEof_q;

endmodule
